// File: rtl/gat_bram_load_bridge_pkg.sv
// gat_bram_load_bridge_pkg: shared types, status field offsets and width mask helper for the GAT BRAM load bridge
package gat_bridge_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, START, BUSY, DONE} bridge_state_e;

  localparam int ST_STATE_LSB = 0;
  localparam int ST_DONE_LSB  = 8;
  localparam int ST_MISM_LSB  = 16;
  localparam int ST_REJ_LSB   = 24;

  function automatic logic [63:0] width_mask(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/gat_bram_load_bridge_if.sv
// gat_bram_load_bridge_if: host-side write ports and BRAM-side write strobes for all channels
//   s_din/s_ena/s_wea/s_addra : byte-addressed host writes (driven by master)
//   m_din/m_we/m_addr         : word-addressed, width-masked BRAM writes (driven by slave)
interface gat_bram_load_bridge_if #(
  parameter int NUM_CH    = 3,
  parameter int TOP_WIDTH = 32,
  parameter int ADDR_W    = 18
);
  logic [NUM_CH*TOP_WIDTH-1:0]  s_din;
  logic [NUM_CH-1:0]            s_ena;
  logic [NUM_CH-1:0]            s_wea;
  logic [NUM_CH*(ADDR_W+2)-1:0] s_addra;
  logic [NUM_CH*TOP_WIDTH-1:0]  m_din;
  logic [NUM_CH-1:0]            m_we;
  logic [NUM_CH*ADDR_W-1:0]     m_addr;

  modport master (output s_din, s_ena, s_wea, s_addra, input m_din, m_we, m_addr);
  modport slave  (input s_din, s_ena, s_wea, s_addra, output m_din, m_we, m_addr);
endinterface

// File: rtl/gat_bram_load_bridge_wr_ch.sv
// gat_bridge_wr_ch: one write channel - mask, byte-to-word address, registered write, word count, done/mismatch
//   i_acc_en   : writes may be accepted (IDLE or LOAD)
//   i_load     : bridge is in LOAD, ld_done edges are honoured
//   i_clr      : bridge leaving DONE, clears count and flags
//   i_din/i_ena/i_wea/i_addra : host write port
//   i_ld_done  : load-done level for this channel
//   o_din/o_we/o_addr : registered BRAM write
//   o_acc/o_rej       : write accepted / dropped this cycle
//   o_done/o_mismatch : channel load finished / word count differed from DEPTH
module gat_bridge_wr_ch
  import gat_bridge_pkg::*;
#(
  parameter int          TOP_WIDTH = 32,
  parameter int          ADDR_W    = 18,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] DEPTH     = 32'd0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_acc_en,
  input  logic                 i_load,
  input  logic                 i_clr,
  input  logic [TOP_WIDTH-1:0] i_din,
  input  logic                 i_ena,
  input  logic                 i_wea,
  input  logic [ADDR_W+1:0]    i_addra,
  input  logic                 i_ld_done,
  output logic [TOP_WIDTH-1:0] o_din,
  output logic                 o_we,
  output logic [ADDR_W-1:0]    o_addr,
  output logic                 o_acc,
  output logic                 o_rej,
  output logic                 o_done,
  output logic                 o_mismatch
);
  localparam logic [TOP_WIDTH-1:0] MASK = TOP_WIDTH'(width_mask(DATA_W));

  logic                 w_wr;
  logic                 w_acc;
  logic [ADDR_W:0]      w_wcnt_nxt;
  logic                 w_unused;
  logic [ADDR_W:0]      r_wcnt;
  logic [TOP_WIDTH-1:0] r_din;
  logic [ADDR_W-1:0]    r_addr;
  logic                 r_we;
  logic                 r_ld_q;
  logic                 r_done;
  logic                 r_mismatch;

  assign w_wr       = i_ena & i_wea;
  assign w_acc      = w_wr & i_acc_en;
  // count includes a write landing in the same cycle as the ld_done edge
  assign w_wcnt_nxt = r_wcnt + {{ADDR_W{1'b0}}, w_acc & ~&r_wcnt};
  assign w_unused   = ^i_addra[1:0];

  always_ff @(posedge clk)
    if (!rst_n) begin
      r_we       <= 1'b0;
      r_din      <= '0;
      r_addr     <= '0;
      r_ld_q     <= 1'b0;
      r_wcnt     <= '0;
      r_done     <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      r_we   <= w_acc;
      r_din  <= w_acc ? i_din & MASK : '0;
      r_addr <= w_acc ? i_addra[ADDR_W+1:2] : '0;
      r_ld_q <= i_ld_done;
      if (i_clr) begin
        r_wcnt     <= '0;
        r_done     <= 1'b0;
        r_mismatch <= 1'b0;
      end else begin
        r_wcnt <= w_wcnt_nxt;
        if (i_load && i_ld_done && !r_ld_q && !r_done) begin
          r_done     <= 1'b1;
          r_mismatch <= 32'(w_wcnt_nxt) != DEPTH;
        end
      end
    end

  assign o_din      = r_din;
  assign o_we       = r_we;
  assign o_addr     = r_addr;
  assign o_acc      = w_acc;
  assign o_rej      = w_wr & ~i_acc_en;
  assign o_done     = r_done;
  assign o_mismatch = r_mismatch;
endmodule

// File: rtl/gat_bram_load_bridge.sv
// gat_bram_load_bridge: host-to-GAT-core bridge - per-channel BRAM loads, load/start/busy/done sequencing, feature readback
//   clk, rst_n (sync, active-low); bus (slave): channel write ports
//   gat_layer, ld_done          : register-bank controls
//   core_start/core_layer/core_ready : core handshake
//   rd_en/rd_addrb/m_rd_addr/m_rd_dout/rd_dout/rd_valid : latency-matched feature readback
//   status, perf_cycles, irq    : reporting
// Optional: GAT_BRIDGE_PERF_CNT_EN builds the busy-cycle counter; otherwise perf_cycles is 0.
module gat_bram_load_bridge
  import gat_bridge_pkg::*;
#(
  parameter int                  NUM_CH    = 3,
  parameter int                  TOP_WIDTH = 32,
  parameter int                  ADDR_W    = 18,
  parameter logic [NUM_CH*8-1:0]  CH_DATA_W = {8'd8, 8'd20, 8'd19},
  parameter logic [NUM_CH*32-1:0] CH_DEPTH  = {32'd22928, 32'd13264, 32'd242101},
  parameter int                  RD_LAT    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   gat_layer,
  input  logic [NUM_CH-1:0]      ld_done,
  gat_bram_load_bridge_if.slave  bus,
  output logic                   core_start,
  output logic                   core_layer,
  input  logic                   core_ready,
  input  logic                   rd_en,
  input  logic [ADDR_W+1:0]      rd_addrb,
  output logic [ADDR_W-1:0]      m_rd_addr,
  input  logic [TOP_WIDTH-1:0]   m_rd_dout,
  output logic [TOP_WIDTH-1:0]   rd_dout,
  output logic                   rd_valid,
  output logic [TOP_WIDTH-1:0]   status,
  output logic [TOP_WIDTH-1:0]   perf_cycles,
  output logic                   irq
);
  bridge_state_e               r_state;
  logic                        r_start;
  logic                        r_layer;
  logic                        r_irq;
  logic [7:0]                  r_rej;
  logic [RD_LAT:0]             r_vp;
  logic [ADDR_W-1:0]           r_rd_addr;
  logic                        w_acc_en;
  logic                        w_load;
  logic                        w_clr;
  logic [NUM_CH-1:0]           w_acc;
  logic [NUM_CH-1:0]           w_rej;
  logic [NUM_CH-1:0]           w_done;
  logic [NUM_CH-1:0]           w_mism;
  logic [NUM_CH*TOP_WIDTH-1:0] w_m_din;
  logic [NUM_CH-1:0]           w_m_we;
  logic [NUM_CH*ADDR_W-1:0]    w_m_addr;
  logic [8:0]                  w_rej_tot;
  logic                        w_unused;

  assign w_acc_en = r_state == IDLE || r_state == LOAD;
  assign w_load   = r_state == LOAD;
  assign w_clr    = r_state == DONE && ld_done == '0;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    gat_bridge_wr_ch #(
      .TOP_WIDTH(TOP_WIDTH),
      .ADDR_W   (ADDR_W),
      .DATA_W   (int'(CH_DATA_W[c*8 +: 8])),
      .DEPTH    (CH_DEPTH[c*32 +: 32])
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_acc_en  (w_acc_en),
      .i_load    (w_load),
      .i_clr     (w_clr),
      .i_din     (bus.s_din[c*TOP_WIDTH +: TOP_WIDTH]),
      .i_ena     (bus.s_ena[c]),
      .i_wea     (bus.s_wea[c]),
      .i_addra   (bus.s_addra[c*(ADDR_W+2) +: ADDR_W+2]),
      .i_ld_done (ld_done[c]),
      .o_din     (w_m_din[c*TOP_WIDTH +: TOP_WIDTH]),
      .o_we      (w_m_we[c]),
      .o_addr    (w_m_addr[c*ADDR_W +: ADDR_W]),
      .o_acc     (w_acc[c]),
      .o_rej     (w_rej[c]),
      .o_done    (w_done[c]),
      .o_mismatch(w_mism[c])
    );
  end

  assign bus.m_din  = w_m_din;
  assign bus.m_we   = w_m_we;
  assign bus.m_addr = w_m_addr;

  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state <= IDLE;
      r_start <= 1'b0;
      r_layer <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_irq   <= 1'b0;
      case (r_state)
        IDLE:    if (|w_acc) r_state <= LOAD;
        LOAD:    if (&w_done) begin
                   r_state <= START;
                   r_start <= 1'b1;
                 end
        START:   begin
                   r_state <= BUSY;
                   r_layer <= gat_layer;
                 end
        BUSY:    if (core_ready) begin
                   r_state <= DONE;
                   r_irq   <= 1'b1;
                 end
        DONE:    if (w_clr) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end

  // several channels can be rejected in one cycle
  assign w_rej_tot = {1'b0, r_rej} + 9'($countones(w_rej));

  always_ff @(posedge clk)
    if (!rst_n) r_rej <= '0;
    else r_rej <= w_rej_tot[8] ? 8'hFF : w_rej_tot[7:0];

`ifdef GAT_BRIDGE_PERF_CNT_EN
  logic [TOP_WIDTH-1:0] r_perf;
  always_ff @(posedge clk)
    if (!rst_n) r_perf <= '0;
    else if (r_state == START) r_perf <= '0;
    else if (r_state == BUSY && r_perf != '1) r_perf <= r_perf + TOP_WIDTH'(1);
  assign perf_cycles = r_perf;
`else
  assign perf_cycles = '0;
`endif

  // valid walks RD_LAT+1 stages: one for the address register, RD_LAT for the BRAM
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_vp      <= '0;
      r_rd_addr <= '0;
    end else begin
      r_vp <= (r_vp << 1) | (RD_LAT+1)'(rd_en);
      if (rd_en) r_rd_addr <= rd_addrb[ADDR_W+1:2];
    end

  assign w_unused  = ^rd_addrb[1:0];
  assign m_rd_addr = r_rd_addr;
  assign rd_valid  = r_vp[RD_LAT];
  assign rd_dout   = rd_valid ? m_rd_dout : '0;

  always_comb begin
    status = '0;
    status[ST_STATE_LSB +: 3]    = r_state;
    status[ST_DONE_LSB +: NUM_CH] = w_done;
    status[ST_MISM_LSB +: NUM_CH] = w_mism;
    status[ST_REJ_LSB +: 8]      = r_rej;
  end

  assign core_start = r_start;
  assign core_layer = r_layer;
  assign irq        = r_irq;
endmodule

// File: tb/tb_gat_bram_load_bridge.sv
// tb_gat_bram_load_bridge: directed self-checking bench for gat_bram_load_bridge
module tb_gat_bram_load_bridge;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gat_layer = 1'b0;
  logic        core_ready = 1'b0;
  logic        rd_en = 1'b0;
  logic [2:0]  ld_done = '0;
  logic [19:0] rd_addrb = '0;
  logic [31:0] m_rd_dout;
  logic        core_start, core_layer, irq, rd_valid;
  logic [17:0] m_rd_addr;
  logic [31:0] rd_dout, status, perf_cycles;
  logic [17:0] b1;
  logic [31:0] b2;
  int checks = 0;
  int errors = 0;

  gat_bram_load_bridge_if #(.NUM_CH(3), .TOP_WIDTH(32), .ADDR_W(18)) bus ();

  gat_bram_load_bridge #(
    .NUM_CH(3), .TOP_WIDTH(32), .ADDR_W(18),
    .CH_DATA_W({8'd8, 8'd20, 8'd19}),
    .CH_DEPTH({32'd2, 32'd3, 32'd5}),
    .RD_LAT(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .gat_layer(gat_layer), .ld_done(ld_done), .bus(bus),
    .core_start(core_start), .core_layer(core_layer), .core_ready(core_ready),
    .rd_en(rd_en), .rd_addrb(rd_addrb), .m_rd_addr(m_rd_addr), .m_rd_dout(m_rd_dout),
    .rd_dout(rd_dout), .rd_valid(rd_valid), .status(status), .perf_cycles(perf_cycles), .irq(irq)
  );

  always #5 clk = ~clk;

  // feature BRAM: two-cycle latency from m_rd_addr, content C0DE_0000 | word address
  always @(posedge clk) begin
    b1 <= m_rd_addr;
    b2 <= 32'hC0DE_0000 | {14'd0, b1};
  end
  assign m_rd_dout = b2;

  task automatic clear_in();
    bus.s_din = '0; bus.s_ena = '0; bus.s_wea = '0; bus.s_addra = '0;
    ld_done = '0; core_ready = 1'b0; rd_en = 1'b0; rd_addrb = '0; gat_layer = 1'b0;
  endtask

  task automatic do_reset();
    clear_in();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({bus.m_we, core_start, core_layer, irq, rd_valid} !== 7'd0) begin errors++; $display("FAIL reset_flags: got %b want 0", {bus.m_we, core_start, core_layer, irq, rd_valid}); end
    checks++; if (bus.m_din !== 96'd0) begin errors++; $display("FAIL reset_m_din: got %h want 0", bus.m_din); end
    checks++; if (bus.m_addr !== 54'd0) begin errors++; $display("FAIL reset_m_addr: got %h want 0", bus.m_addr); end
    checks++; if (status !== 32'd0) begin errors++; $display("FAIL reset_status: got %h want 0", status); end
    checks++; if (perf_cycles !== 32'd0) begin errors++; $display("FAIL reset_perf: got %h want 0", perf_cycles); end
    checks++; if ({rd_dout, m_rd_addr} !== 50'd0) begin errors++; $display("FAIL reset_rd: got %h want 0", {rd_dout, m_rd_addr}); end
  endtask

  task automatic test_write_path();
    do_reset();
    bus.s_ena = 3'b111; bus.s_wea = 3'b111;
    bus.s_din = {32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    bus.s_addra = {20'h003FC, 20'h00008, 20'h00010};
    @(negedge clk);
    bus.s_ena = 3'b001; bus.s_wea = 3'b000;
    checks++; if (bus.m_we !== 3'b111) begin errors++; $display("FAIL wr_we: got %b want 111", bus.m_we); end
    checks++; if (bus.m_addr[17:0] !== 18'd4) begin errors++; $display("FAIL wr_addr0: got %h want 4", bus.m_addr[17:0]); end
    checks++; if (bus.m_addr[35:18] !== 18'd2) begin errors++; $display("FAIL wr_addr1: got %h want 2", bus.m_addr[35:18]); end
    checks++; if (bus.m_addr[53:36] !== 18'hFF) begin errors++; $display("FAIL wr_addr2: got %h want ff", bus.m_addr[53:36]); end
    checks++; if (bus.m_din[31:0] !== 32'h0007_FFFF) begin errors++; $display("FAIL wr_din0: got %h want 0007ffff", bus.m_din[31:0]); end
    checks++; if (bus.m_din[63:32] !== 32'h000F_FFFF) begin errors++; $display("FAIL wr_din1: got %h want 000fffff", bus.m_din[63:32]); end
    checks++; if (bus.m_din[95:64] !== 32'h0000_0078) begin errors++; $display("FAIL wr_din2: got %h want 00000078", bus.m_din[95:64]); end
    checks++; if (status[2:0] !== 3'd1) begin errors++; $display("FAIL wr_state_load: got %0d want 1", status[2:0]); end
    @(negedge clk);
    bus.s_ena = '0;
    checks++; if (bus.m_we !== 3'b000) begin errors++; $display("FAIL wr_ena_only: got %b want 000", bus.m_we); end
  endtask

  task automatic test_load_start();
    int n;
    do_reset();
    gat_layer = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.s_ena = {(i < 1), (i < 3), 1'b1};
      bus.s_wea = bus.s_ena;
      bus.s_addra = {3{20'(i * 4)}};
      bus.s_din = {3{32'(i + 1)}};
      @(negedge clk);
    end
    bus.s_ena = 3'b100; bus.s_wea = 3'b100; ld_done = 3'b111;
    @(negedge clk);
    bus.s_ena = '0; bus.s_wea = '0; ld_done = '0;
    checks++; if (status[15:8] !== 8'h07) begin errors++; $display("FAIL ld_done_flags: got %h want 07", status[15:8]); end
    checks++; if (status[23:16] !== 8'h00) begin errors++; $display("FAIL ld_mismatch: got %h want 00", status[23:16]); end
    n = 0;
    while (core_start !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL start_seen: got %b want 1", core_start); end
    checks++; if (status[2:0] !== 3'd2) begin errors++; $display("FAIL start_state: got %0d want 2", status[2:0]); end
    @(negedge clk);
    checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL start_single: got %b want 0", core_start); end
    checks++; if (status[2:0] !== 3'd3) begin errors++; $display("FAIL busy_state: got %0d want 3", status[2:0]); end
    checks++; if (core_layer !== 1'b1) begin errors++; $display("FAIL core_layer: got %b want 1", core_layer); end
  endtask

  // entered in the first BUSY cycle left by test_load_start
  task automatic test_busy_irq_perf();
    int busy = 1;
    int guard = 0;
    logic [31:0] perf_exp;
`ifdef GAT_BRIDGE_PERF_CNT_EN
    perf_exp = 32'd100;
`else
    perf_exp = 32'd0;
`endif
    while (busy < 100 && guard < 300) begin
      bus.s_ena = (busy >= 10 && busy <= 12) ? 3'b001 : 3'b000;
      bus.s_wea = bus.s_ena;
      bus.s_din = 32'hDEAD_BEEF;
      @(negedge clk);
      guard++;
      checks++; if (bus.m_we !== 3'b000) begin errors++; $display("FAIL busy_no_we: got %b want 000 at busy %0d", bus.m_we, busy); end
      if (status[2:0] === 3'd3) busy++;
      else begin
        checks++; errors++; $display("FAIL busy_dwell: got state %0d want 3 at busy %0d", status[2:0], busy);
        break;
      end
    end
    bus.s_ena = '0; bus.s_wea = '0; core_ready = 1'b1;
    @(negedge clk);
    core_ready = 1'b0;
    checks++; if (status[2:0] !== 3'd4) begin errors++; $display("FAIL done_state: got %0d want 4", status[2:0]); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_high: got %b want 1", irq); end
    checks++; if (perf_cycles !== perf_exp) begin errors++; $display("FAIL perf_cycles: got %0d want %0d", perf_cycles, perf_exp); end
    checks++; if (status[31:24] !== 8'd3) begin errors++; $display("FAIL rej_cnt: got %0d want 3", status[31:24]); end
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_pulse: got %b want 0", irq); end
    checks++; if (status !== 32'h0300_0000) begin errors++; $display("FAIL idle_status: got %h want 03000000", status); end
    checks++; if (perf_cycles !== perf_exp) begin errors++; $display("FAIL perf_hold: got %0d want %0d", perf_cycles, perf_exp); end
  endtask

  task automatic test_mismatch();
    int n;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.s_ena = {(i < 2), (i < 2), 1'b1};
      bus.s_wea = bus.s_ena;
      bus.s_addra = {3{20'(i * 4)}};
      @(negedge clk);
    end
    bus.s_ena = '0; bus.s_wea = '0; ld_done = 3'b111;
    @(negedge clk);
    ld_done = '0;
    checks++; if (status[23:16] !== 8'h02) begin errors++; $display("FAIL mismatch_ch1: got %h want 02", status[23:16]); end
    checks++; if (status[15:8] !== 8'h07) begin errors++; $display("FAIL mismatch_done: got %h want 07", status[15:8]); end
    n = 0;
    while (core_start !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL mismatch_start: got %b want 1", core_start); end
  endtask

  task automatic test_readback();
    logic [31:0] exp_d;
    logic        exp_v;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      exp_v = c >= 3 && c <= 5;
      exp_d = exp_v ? 32'hC0DE_0000 + 32'(c - 3) : 32'd0;
      checks++; if (rd_valid !== exp_v) begin errors++; $display("FAIL rd_valid c%0d: got %b want %b", c, rd_valid, exp_v); end
      checks++; if (rd_dout !== exp_d) begin errors++; $display("FAIL rd_dout c%0d: got %h want %h", c, rd_dout, exp_d); end
      if (c >= 1 && c <= 3) begin
        checks++; if (m_rd_addr !== 18'(c - 1)) begin errors++; $display("FAIL m_rd_addr c%0d: got %h want %h", c, m_rd_addr, c - 1); end
      end
      rd_en = c < 3;
      rd_addrb = 20'(c * 4);
      @(negedge clk);
    end
    rd_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.s_ena = 3'b111; bus.s_wea = 3'b111; bus.s_din = '1; bus.s_addra = {3{20'h00040}};
    rd_en = 1'b1; rd_addrb = 20'h00010;
    @(negedge clk);
    checks++; if (bus.m_we !== 3'b111) begin errors++; $display("FAIL mid_pre_we: got %b want 111", bus.m_we); end
    rst_n = 1'b0; rd_addrb = 20'h00014;
    @(negedge clk);
    checks++; if ({bus.m_we, core_start, core_layer, irq, rd_valid} !== 7'd0) begin errors++; $display("FAIL mid_flags: got %b want 0", {bus.m_we, core_start, core_layer, irq, rd_valid}); end
    checks++; if ({bus.m_din, bus.m_addr} !== 150'd0) begin errors++; $display("FAIL mid_wr_bus: got %h want 0", {bus.m_din, bus.m_addr}); end
    checks++; if (status !== 32'd0) begin errors++; $display("FAIL mid_status: got %h want 0", status); end
    checks++; if ({perf_cycles, rd_dout, m_rd_addr} !== 82'd0) begin errors++; $display("FAIL mid_rd_perf: got %h want 0", {perf_cycles, rd_dout, m_rd_addr}); end
    clear_in();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL mid_flush k%0d: got %b want 0", k, rd_valid); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_path();
    test_load_start();
    test_busy_irq_perf();
    test_mismatch();
    test_readback();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
